multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath: one shared memory, IR, ALU reused per step.
//  Decodes IR opcode, drives datapath mux/enable controls, stalls on memory handshake, stops on halt.
//  Keeps cycle and retired-instruction counters for the bench. Sits beside the datapath top level.
// PARAMETERS
//  OPC_RTYPE  6'b000000  R-type opcode
//  OPC_LW     6'b100011  load word opcode
//  OPC_SW     6'b101011  store word opcode
//  OPC_BEQ    6'b000100  branch-equal opcode
//  OPC_HALT   6'b111111  halt opcode (all-ones instruction)
//  CNT_W      32         width of cycle_count / instr_count
// PORTS
//  clock          in   1      system clock, all state updates on posedge
//  reset_n        in   1      asynchronous, active-low reset
//  start          in   1      leave IDLE and begin fetching
//  opcode         in   6      IR[31:26]; stable from DECODE until next FETCH
//  mem_ready      in   1      memory completes read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero
//  pc_source      out  2      00 ALU result, 01 ALUOut (branch target)
//  i_or_d         out  1      memory address: 0 PC, 1 ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      IR load
//  reg_dst        out  1      write reg: 0 rt, 1 rd
//  mem_to_reg     out  1      write data: 0 ALUOut, 1 MDR
//  reg_write      out  1      register-file write enable
//  alu_src_a      out  1      ALU A: 0 PC, 1 reg A
//  alu_src_b      out  2      ALU B: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  2      to ALU control: 00 add, 01 sub, 10 funct field
//  illegal        out  1      one-cycle pulse: unknown opcode seen in DECODE
//  halted         out  1      high while in HALT
//  state          out  4      current state encoding (debug)
//  cycle_count    out  CNT_W  active cycles since reset
//  instr_count    out  CNT_W  retired instructions since reset
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8 BRANCH=9 HALT=10.
//  Reset (async, any state): state=IDLE, counters=0; all outputs 0 (defaults listed as 0 below).
//  Controls are pure decode of state (+mem_ready where noted); unlisted outputs are 0.
//  IDLE: start=1 -> FETCH, else stay.
//  FETCH: mem_read=1, alu_src_b=01; ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE, else stay.
//  DECODE: alu_src_b=11 (precompute branch target). Next by opcode: LW/SW->MEMADR, RTYPE->EXEC,
//   BEQ->BRANCH, HALT->HALT, other->FETCH with illegal=1 that cycle (not retired).
//  MEMADR: alu_src_a=1, alu_src_b=10. LW->MEMRD, SW->MEMWR.
//  MEMRD: mem_read=1, i_or_d=1; mem_ready=1 -> MEMWB, else stay.
//  MEMWB: reg_write=1, mem_to_reg=1 -> FETCH (retire).
//  MEMWR: mem_write=1, i_or_d=1; mem_ready=1 -> FETCH (retire), else stay; write commits once.
//  EXEC: alu_src_a=1, alu_op=10 -> ALUWB.  ALUWB: reg_dst=1, reg_write=1 -> FETCH (retire).
//  BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH (retire).
//  HALT: halted=1; terminal; start ignored; exit only via reset_n. HALT is retired once on entry.
//  Latency with mem_ready tied 1: LW 5, SW 4, R-type 4, BEQ 3 cycles FETCH-to-FETCH.
//  Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle; no other state waits.
//  cycle_count: +1 every clock with state not IDLE/HALT; instr_count: +1 on each retire transition.
//  Both counters saturate at all-ones (no wrap).
//  opcode is sampled only in DECODE and MEMADR; changes in other states have no effect.
//  Reset asserted mid-MEMWR drops mem_write immediately (async), no retire counted.
// TESTING
//  Reset, start=1 1 cycle, opcode=LW, mem_ready=1 -> states 1,2,3,4,5,1; instr_count=1, cycle_count=5.
//  SW with mem_ready=0 for 2 cycles in MEMWR -> mem_write high 3 cycles, one retire, 6 cycles total.
//  R-type then BEQ, mem_ready=1 -> ALUWB has reg_dst=1,reg_write=1; BRANCH has pc_write_cond=1,
//   pc_source=01, alu_op=01; instr_count=2 after 7 cycles.
//  opcode=6'b010101 -> illegal pulses 1 cycle in DECODE, back to FETCH, instr_count unchanged.
//  opcode=6'b111111 -> HALT, halted=1, counters frozen 20 cycles, start=1 ignored.
//  reset_n low mid-MEMWR -> same-cycle state=0, all outputs 0, counters 0; start restarts at FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for a multi-cycle MIPS datapath that shares one memory, the IR and the ALU
//   across the steps of each instruction. It decodes the IR opcode, drives the datapath mux and
//   enable controls, waits on the memory handshake and stops on a halt instruction. It also keeps
//   a cycle counter and a retired-instruction counter for the bench.
//
// Ports
//   clock, reset_n           clock (posedge) and asynchronous active-low reset
//   start                    leave IDLE and begin fetching
//   opcode[5:0]              IR[31:26]; only looked at in DECODE and MEMADR
//   mem_ready                memory completes the current read/write this cycle
//   pc_write, pc_write_cond  unconditional / zero-conditional PC load
//   pc_source[1:0]           PC source: 00 ALU result, 01 ALUOut (branch target)
//   i_or_d                   memory address: 0 PC, 1 ALUOut
//   mem_read, mem_write      memory requests
//   ir_write                 IR load
//   reg_dst, mem_to_reg      register-file write address / data selects
//   reg_write                register-file write enable
//   alu_src_a, alu_src_b     ALU operand selects
//   alu_op[1:0]              ALU control: 00 add, 01 sub, 10 funct field
//   illegal                  one-cycle pulse when DECODE sees an unknown opcode
//   halted                   high while in HALT
//   state[3:0]               current state encoding (debug)
//   cycle_count, instr_count active cycles and retired instructions since reset (saturating)

module multicycle_control #(
    parameter logic [5:0]  OPC_RTYPE = 6'b000000,
    parameter logic [5:0]  OPC_LW    = 6'b100011,
    parameter logic [5:0]  OPC_SW    = 6'b101011,
    parameter logic [5:0]  OPC_BEQ   = 6'b000100,
    parameter logic [5:0]  OPC_HALT  = 6'b111111,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StHalt   = 4'd10
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state != StIdle && r_state != StHalt && r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (w_retire && r_instr_count != '1) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_retire      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        halted        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (start) w_state_next = StFetch;
            end
            StFetch: begin
                // ALU computes PC+4 while the instruction is read
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_state_next = StDecode;
            end
            StDecode: begin
                // Branch target precomputed speculatively in ALUOut
                alu_src_b = 2'b11;
                if (opcode == OPC_LW || opcode == OPC_SW) begin
                    w_state_next = StMemAdr;
                end else if (opcode == OPC_RTYPE) begin
                    w_state_next = StExec;
                end else if (opcode == OPC_BEQ) begin
                    w_state_next = StBranch;
                end else if (opcode == OPC_HALT) begin
                    w_state_next = StHalt;
                    w_retire     = 1'b1;
                end else begin
                    w_state_next = StFetch;
                    illegal      = 1'b1;
                end
            end
            StMemAdr: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = (opcode == OPC_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_state_next = StMemWb;
            end
            StMemWb: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    w_state_next = StFetch;
                    w_retire     = 1'b1;
                end
            end
            StExec: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                reg_dst      = 1'b1;
                reg_write    = 1'b1;
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_state_next  = StFetch;
                w_retire      = 1'b1;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign state       = r_state;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule
